alu_execute_stage: RTL and testbench
====================================

// Module: alu_execute_stage
// PURPOSE
//  Execute-stage consumer of the 3-bit ALUControl code emitted by the ALU decoder. Computes the
//  operation, registers result and flags, and presents them to the memory stage through a
//  valid/ready handshake backed by a 2-entry output buffer. Sits between the ID/EX register and
//  EX/MEM. Provides Zero for branch resolution and flags for overflow/trap logic.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>= 2)
//  TAGW     5  width of the passthrough tag (destination register index)
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  flush        in   1      synchronous kill of all buffered results (branch mispredict)
//  in_valid     in   1      operands/control valid this cycle
//  in_ready     out  1      stage can accept; transfer when in_valid && in_ready
//  alu_ctrl     in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; 100/110/111 reserved
//  src_a        in   WIDTH  operand A
//  src_b        in   WIDTH  operand B (register or immediate, already muxed)
//  tag_in       in   TAGW   passthrough tag
//  out_valid    out  1      result at head of buffer valid
//  out_ready    in   1      consumer accepts; transfer when out_valid && out_ready
//  result       out  WIDTH  head result
//  tag_out      out  TAGW   head tag
//  zero         out  1      head result == 0
//  negative     out  1      head result[WIDTH-1]
//  carry        out  1      ADD: carry-out; SUB: 1 when no borrow (A >=u B); else 0
//  overflow     out  1      ADD/SUB signed overflow; else 0
//  illegal      out  1      head entry used a reserved alu_ctrl
// BEHAVIOUR
//  - Reset: buffer emptied; out_valid=0, in_ready=1, result/tag_out=0, all flags 0.
//  - Latency: accepted operands appear at result exactly 1 cycle later when the buffer was empty;
//    one result per cycle sustained while out_ready=1.
//  - Arithmetic: ADD = A+B mod 2^WIDTH; SUB = A+~B+1; SLT = {0..0, signed(A)<signed(B)}
//    (from SUB sign xor overflow); AND/OR bitwise. Reserved codes: result=0, illegal=1, zero=1.
//  - Overflow: ADD: A,B same sign, result sign differs. SUB: A,B differ in sign, result sign != A.
//  - Buffer: 2 entries, FIFO order, head drives outputs. count in {0,1,2}.
//    in_ready = (count<2) || out_ready  (registered-free skid: accept while popping when full).
//    Push and pop in same cycle: count unchanged, new entry enters behind remaining one.
//    in_valid with in_ready=0: input ignored; upstream must hold operands stable.
//  - out_valid = (count!=0). While out_valid && !out_ready, result/tag/flags held stable.
//  - flush: next edge count=0, out_valid=0; any same-cycle input transfer is also discarded.
//    flush has priority over push and pop.
//  - Outputs when out_valid=0: result/tag/flags hold last value (not guaranteed zero after reset).
//  - Reset asserted mid-operation: buffer cleared immediately (async), no partial entry retained.
// TESTING
//  1. ADD 0x7FFFFFFF+1, tag 3, out_ready=1 -> next cycle result 0x80000000, overflow=1, negative=1,
//     carry=0, tag_out=3.
//  2. SUB 5-5 -> result 0, zero=1, carry=1; SUB 0-1 -> 0xFFFFFFFF, carry=0, overflow=0.
//  3. SLT A=0xFFFFFFFF (-1), B=1 -> result 1; SLT A=1, B=0xFFFFFFFF -> result 0;
//     SLT A=0x80000000, B=1 -> result 1 (overflowing subtract).
//  4. out_ready=0, push 3 ops back-to-back -> first two buffered, in_ready=0 on third, third held;
//     raise out_ready -> results drain in order, one per cycle, none lost or duplicated.
//  5. Buffer holds 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, count=0;
//     following op emerges alone with latency 1.
//  6. alu_ctrl=3'b110 -> illegal=1, result 0, zero=1; assert rst mid-stream -> out_valid drops
//     asynchronously, in_ready=1.

Source files
------------

// File: rtl/alu_execute_stage.sv
// Execute stage: evaluates the ALU operation selected by alu_ctrl and queues the
// result with its flags and tag in a 2-entry FIFO toward the memory stage.
module alu_execute_stage #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [TAGW-1:0]  tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAGW-1:0]  tag_out,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [TAGW-1:0]  tag;
        logic             z;
        logic             n;
        logic             c;
        logic             v;
        logic             il;
    } entry_t;

    entry_t     head_reg, head_next;
    entry_t     tail_reg, tail_next;
    entry_t     new_entry;
    logic [1:0] count_reg, count_next;

    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic           add_ovf;
    logic           sub_ovf;
    logic           push;
    logic           pop;

    assign sum_ext  = {1'b0, src_a} + {1'b0, src_b};
    assign diff_ext = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

    assign add_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_ext[WIDTH-1] != src_a[WIDTH-1]);
    assign sub_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff_ext[WIDTH-1] != src_a[WIDTH-1]);

    always_comb begin
        new_entry     = '0;
        new_entry.tag = tag_in;
        case (alu_ctrl)
            3'b000: begin
                new_entry.res = sum_ext[WIDTH-1:0];
                new_entry.c   = sum_ext[WIDTH];
                new_entry.v   = add_ovf;
            end
            3'b001: begin
                // carry-out of A + ~B + 1 is the "no borrow" indication
                new_entry.res = diff_ext[WIDTH-1:0];
                new_entry.c   = diff_ext[WIDTH];
                new_entry.v   = sub_ovf;
            end
            3'b010: new_entry.res = src_a & src_b;
            3'b011: new_entry.res = src_a | src_b;
            3'b101: new_entry.res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH-1] ^ sub_ovf};
            default: new_entry.il = 1'b1;
        endcase
        new_entry.z = (new_entry.res == '0);
        new_entry.n = new_entry.res[WIDTH-1];
    end

    assign out_valid = (count_reg != 2'd0);
    assign in_ready  = (count_reg != 2'd2) || out_ready;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            // head contents are kept so the outputs hold their last value
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count_reg == 2'd1) begin
                        head_next = new_entry;
                    end else begin
                        head_next = tail_reg;
                        tail_next = new_entry;
                    end
                end
                2'b10: begin
                    if (count_reg == 2'd0) begin
                        head_next  = new_entry;
                        count_next = 2'd1;
                    end else begin
                        tail_next  = new_entry;
                        count_next = 2'd2;
                    end
                end
                2'b01: begin
                    if (count_reg == 2'd2) begin
                        head_next = tail_reg;
                    end
                    count_next = count_reg - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= 2'd0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign result   = head_reg.res;
    assign tag_out  = head_reg.tag;
    assign zero     = head_reg.z;
    assign negative = head_reg.n;
    assign carry    = head_reg.c;
    assign overflow = head_reg.v;
    assign illegal  = head_reg.il;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for alu_execute_stage: vector table for the arithmetic, plus
// hand-written sequences for backpressure, flush and asynchronous reset.
module tb_alu_execute_stage;

    localparam int WIDTH = 32;
    localparam int TAGW  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [TAGW-1:0]  tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAGW-1:0]  tag_out;
    logic             zero, negative, carry, overflow, illegal;

    int checks   = 0;
    int failures = 0;

    alu_execute_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .tag_out(tag_out),
        .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic [4:0]       flags; // {zero, negative, carry, overflow, illegal}
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [TAGW-1:0] t);
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        tag_in   = t;
        in_valid = 1'b1;
    endtask

    function automatic logic [63:0] head_bundle();
        return {21'd0, out_valid, result, tag_out, zero, negative, carry, overflow, illegal};
    endfunction

    function automatic logic [63:0] exp_bundle(input logic v, input logic [WIDTH-1:0] r,
                                               input logic [TAGW-1:0] t, input logic [4:0] f);
        return {21'd0, v, r, t, f};
    endfunction

    initial begin
        vecs[0]  = '{3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010};
        vecs[1]  = '{3'b001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 5'b10100};
        vecs[2]  = '{3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 5'b01000};
        vecs[3]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00000};
        vecs[4]  = '{3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 5'b10000};
        vecs[5]  = '{3'b101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 5'b00000};
        vecs[6]  = '{3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 5'b01000};
        vecs[7]  = '{3'b011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 5'b00000};
        vecs[8]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10100};
        vecs[9]  = '{3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00110};
        vecs[10] = '{3'b110, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 5'b10001};
        vecs[11] = '{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5'b10001};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = 3'b000; src_a = '0; src_b = '0; tag_in = '0;
        repeat (2) tick();
        check("reset_head", head_bundle(), exp_bundle(1'b0, '0, '0, 5'b00000));
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;
        tick();

        // back-to-back ops with out_ready=1: one result per cycle, latency 1
        for (int i = 0; i < 12; i++) begin
            set_op(vecs[i].op, vecs[i].a, vecs[i].b, TAGW'(i + 3));
            tick();
            check($sformatf("vec%0d", i), head_bundle(),
                  exp_bundle(1'b1, vecs[i].res, TAGW'(i + 3), vecs[i].flags));
        end
        in_valid = 1'b0;
        tick();
        check("drain_empty", {63'd0, out_valid}, 64'd0);
        check("hold_after_empty", {32'd0, result}, {32'd0, vecs[11].res});

        // backpressure: two buffered, third held, then in-order drain
        out_ready = 1'b0;
        set_op(3'b000, 32'd1, 32'd1, 5'd1);
        tick();
        set_op(3'b000, 32'd2, 32'd2, 5'd2);
        tick();
        set_op(3'b000, 32'd3, 32'd3, 5'd3);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_head", head_bundle(), exp_bundle(1'b1, 32'd2, 5'd1, 5'b00000));
        tick();
        check("stall_head", head_bundle(), exp_bundle(1'b1, 32'd2, 5'd1, 5'b00000));
        out_ready = 1'b1;
        #1;
        check("skid_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("drain1", head_bundle(), exp_bundle(1'b1, 32'd4, 5'd2, 5'b00000));
        tick();
        check("drain2", head_bundle(), exp_bundle(1'b1, 32'd6, 5'd3, 5'b00000));
        tick();
        check("drain_done", {63'd0, out_valid}, 64'd0);

        // flush with a full buffer and a simultaneous input
        out_ready = 1'b0;
        set_op(3'b011, 32'h10, 32'h01, 5'd10);
        tick();
        set_op(3'b011, 32'h20, 32'h02, 5'd11);
        tick();
        set_op(3'b011, 32'h40, 32'h04, 5'd12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        set_op(3'b001, 32'd9, 32'd4, 5'd7);
        tick();
        in_valid = 1'b0;
        check("post_flush_op", head_bundle(), exp_bundle(1'b1, 32'd5, 5'd7, 5'b00100));
        tick();
        check("post_flush_alone", {63'd0, out_valid}, 64'd0);

        // asynchronous reset in the middle of a stalled stream
        out_ready = 1'b0;
        set_op(3'b000, 32'd8, 32'd8, 5'd9);
        tick();
        set_op(3'b000, 32'd1, 32'd2, 5'd4);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_ready", {63'd0, in_ready}, 64'd1);
        check("async_rst_head", head_bundle(), exp_bundle(1'b0, '0, '0, 5'b00000));
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("after_rst_empty", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
